// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, baud divider, optional parity, 1/2 stop.
// Ports: CLK/RST, P_DATA+DATA_VALID/DATA_READY push side, PAR_EN, PAR_TYP,
// STOP2, PRESCALE (bit period), TX_OUT serial line, Busy, FIFO_LEVEL.
module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          DATA_VALID,
    output logic                          DATA_READY,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    input  logic [PRESCALE_WIDTH-1:0]     PRESCALE,
    output logic                          TX_OUT,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               level;
    logic [DATA_WIDTH-1:0]     head;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      par_bit;
    logic                      par_en_q;
    logic                      stop2_q;
    logic                      stop_idx;
    logic [PRESCALE_WIDTH-1:0] n_q;
    logic [PRESCALE_WIDTH-1:0] n_eff;
    logic [PRESCALE_WIDTH-1:0] baud_cnt;
    logic [BW-1:0]             bit_idx;
    logic                      push;
    logic                      pop;
    logic                      bit_end;
    logic                      last_stop;
    logic                      fifo_ne;

    assign DATA_READY = (level != FULL_LVL);
    assign FIFO_LEVEL = level;
    assign push       = DATA_VALID && DATA_READY;
    assign fifo_ne    = (level != '0);
    assign head       = mem[rd_ptr];
    assign n_eff      = (PRESCALE == '0) ? ONE : PRESCALE;
    assign bit_end    = (baud_cnt == '0);
    assign last_stop  = (stop_idx == stop2_q);

    // Pop either from idle or at the very end of the last stop bit, so
    // queued frames follow each other with no idle cycle.
    assign pop = fifo_ne &&
                 ((state == IDLE) ||
                  (state == STOP && bit_end && last_stop));

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= P_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            stop_idx <= 1'b0;
            n_q      <= ONE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (pop) begin
            state    <= START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
            shreg    <= head;
            par_bit  <= (^head) ^ PAR_TYP;
            par_en_q <= PAR_EN;
            stop2_q  <= STOP2;
            stop_idx <= 1'b0;
            n_q      <= n_eff;
            baud_cnt <= n_eff - ONE;
            bit_idx  <= '0;
        end else begin
            if (state != IDLE) begin
                baud_cnt <= bit_end ? n_q - ONE : baud_cnt - ONE;
            end
            unique case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        TX_OUT  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx != LAST_BIT) begin
                            TX_OUT  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end else if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state    <= STOP;
                            TX_OUT   <= 1'b1;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        TX_OUT   <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            state  <= IDLE;
                            Busy   <= 1'b0;
                            TX_OUT <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames,
// a monitor decodes TX_OUT cycle by cycle and compares.
module tb_uart_tx_fifo;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  P_DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        STOP2;
    logic [15:0] PRESCALE;
    logic        TX_OUT;
    logic        Busy;
    logic [2:0]  FIFO_LEVEL;

    uart_tx_fifo dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        bit         pe;
        bit         pb;
        bit         s2;
        int         n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   abort = 0;
    bit   in_frame = 0;

    function automatic exp_t mk(input logic [7:0] d, input bit pe,
                                input bit pb, input bit s2, input int n);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.pb = pb;
        e.s2 = s2;
        e.n = n;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: detects a start bit, pops the expected frame, then checks
    // every cycle of every bit against the expected waveform.
    initial begin : monitor
        exp_t e;
        bit   bits[16];
        int   nb;
        int   nbad;
        int   bbad;
        int   first_bad;
        bit   aborted;
        forever begin
            @(negedge CLK);
            if (!abort && RST === 1'b1 && TX_OUT === 1'b0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit, none queued");
                    for (int t = 0; t < 2000 && TX_OUT !== 1'b1; t++)
                        @(negedge CLK);
                end else begin
                    e = q.pop_front();
                    nb = 0;
                    bits[nb] = 1'b0;
                    nb = nb + 1;
                    for (int i = 0; i < 8; i++) begin
                        bits[nb] = e.d[i];
                        nb = nb + 1;
                    end
                    if (e.pe) begin
                        bits[nb] = e.pb;
                        nb = nb + 1;
                    end
                    bits[nb] = 1'b1;
                    nb = nb + 1;
                    if (e.s2) begin
                        bits[nb] = 1'b1;
                        nb = nb + 1;
                    end
                    in_frame = 1;
                    aborted = 0;
                    nbad = 0;
                    bbad = 0;
                    first_bad = -1;
                    for (int b = 0; b < nb && !aborted; b++) begin
                        for (int c = 0; c < e.n && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge CLK);
                            if (abort || RST !== 1'b1) begin
                                aborted = 1;
                            end else begin
                                if (TX_OUT !== bits[b]) begin
                                    nbad++;
                                    if (first_bad < 0) first_bad = b;
                                end
                                if (Busy !== 1'b1) bbad++;
                            end
                        end
                    end
                    in_frame = 0;
                    if (!aborted) begin
                        checks++;
                        if (nbad != 0) begin
                            errors++;
                            $display("FAIL frame_%02h: %0d bad cycles, first bad bit %0d, expected bit value %0d",
                                     e.d, nbad, first_bad, bits[first_bad]);
                        end
                        chk($sformatf("busy_in_frame_%02h_low_cycles", e.d),
                            bbad, 0);
                    end
                end
            end
        end
    end

    task automatic push1(input logic [7:0] d, input exp_t e);
        @(negedge CLK);
        P_DATA = d;
        DATA_VALID = 1'b1;
        q.push_back(e);
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        @(negedge CLK);
        while ((q.size() != 0 || in_frame || Busy === 1'b1) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: timeout, %0d frames left", nm, q.size());
        end
    endtask

    task automatic measure_busy(input int exp_len, input string nm);
        int cnt;
        int t;
        cnt = 0;
        t = 0;
        while (Busy !== 1'b1 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (Busy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL busy_rise_%s: got 0 expected 1", nm);
        end else begin
            while (Busy === 1'b1 && cnt < 2000) begin
                cnt++;
                @(negedge CLK);
            end
            chk({"busy_len_", nm}, cnt, exp_len);
        end
    endtask

    initial begin : stim
        int acc;
        logic [7:0] w;
        RST = 1'b0;
        P_DATA = '0;
        DATA_VALID = 1'b0;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        STOP2 = 1'b0;
        PRESCALE = 16'd4;
        #12;
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_level", FIFO_LEVEL, 0);
        chk("rst_ready", DATA_READY, 1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // 0xA5, N=4, no parity, one stop: 40-cycle frame
        fork
            push1(8'hA5, mk(8'hA5, 0, 0, 0, 4));
            measure_busy(40, "a5");
        join
        wait_drain("a5");

        // Parity cases, N=2
        PRESCALE = 16'd2;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        push1(8'h07, mk(8'h07, 1, 1, 0, 2));
        wait_drain("07e");
        PAR_TYP = 1'b1;
        push1(8'h07, mk(8'h07, 1, 0, 0, 2));
        wait_drain("07o");
        PAR_TYP = 1'b0;
        push1(8'h03, mk(8'h03, 1, 0, 0, 2));
        wait_drain("03e");
        STOP2 = 1'b1;
        fork
            push1(8'h03, mk(8'h03, 1, 0, 1, 2));
            measure_busy(24, "03_stop2");
        join
        wait_drain("03s2");
        STOP2 = 1'b0;
        PAR_EN = 1'b0;

        // Three back-to-back frames, N=3
        PRESCALE = 16'd3;
        fork
            begin
                @(negedge CLK);
                P_DATA = 8'h11;
                DATA_VALID = 1'b1;
                q.push_back(mk(8'h11, 0, 0, 0, 3));
                @(negedge CLK);
                P_DATA = 8'h22;
                q.push_back(mk(8'h22, 0, 0, 0, 3));
                @(negedge CLK);
                P_DATA = 8'h33;
                q.push_back(mk(8'h33, 0, 0, 0, 3));
                @(negedge CLK);
                DATA_VALID = 1'b0;
            end
            measure_busy(90, "b2b");
        join
        wait_drain("b2b");

        // FIFO fill with DATA_VALID held high, N=8
        PRESCALE = 16'd8;
        acc = 0;
        w = 8'h40;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (c == 59) begin
                chk("full_level", FIFO_LEVEL, 4);
                chk("full_ready", DATA_READY, 0);
            end
            P_DATA = w;
            DATA_VALID = 1'b1;
            if (DATA_READY === 1'b1) begin
                q.push_back(mk(w, 0, 0, 0, 8));
                acc++;
                w = w + 8'd1;
            end
        end
        @(negedge CLK);
        DATA_VALID = 1'b0;
        chk("full_accepted", acc, 5);
        wait_drain("fill");

        // Config change mid-frame applies only to the next frame
        PRESCALE = 16'd4;
        @(negedge CLK);
        P_DATA = 8'h55;
        DATA_VALID = 1'b1;
        q.push_back(mk(8'h55, 0, 0, 0, 4));
        @(negedge CLK);
        P_DATA = 8'h66;
        q.push_back(mk(8'h66, 1, 0, 0, 2));
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (8) @(negedge CLK);
        PAR_EN = 1'b1;
        PRESCALE = 16'd2;
        wait_drain("cfg");
        PAR_EN = 1'b0;

        // PRESCALE=0 behaves as 1
        PRESCALE = 16'd0;
        fork
            push1(8'h9C, mk(8'h9C, 0, 0, 0, 1));
            measure_busy(10, "n0");
        join
        wait_drain("n0");

        // Asynchronous reset mid-DATA with a word still queued
        PRESCALE = 16'd4;
        @(negedge CLK);
        P_DATA = 8'hC3;
        DATA_VALID = 1'b1;
        q.push_back(mk(8'hC3, 0, 0, 0, 4));
        @(negedge CLK);
        P_DATA = 8'h3C;
        q.push_back(mk(8'h3C, 0, 0, 0, 4));
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (14) @(negedge CLK);
        chk("pre_rst_busy", Busy, 1);
        @(posedge CLK);
        #2;
        abort = 1;
        RST = 1'b0;
        #1;
        chk("arst_tx", TX_OUT, 1);
        chk("arst_busy", Busy, 0);
        chk("arst_level", FIFO_LEVEL, 0);
        chk("arst_ready", DATA_READY, 1);
        q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        abort = 0;
        fork
            push1(8'h5A, mk(8'h5A, 0, 0, 0, 4));
            measure_busy(40, "post_rst");
        join
        wait_drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
